ping_pong_counter: RTL

PING_PONG_COUNTER -- requirements
Module: ping_pong_counter

---
 rtl/ping_pong_counter.sv | 87 ++++++++
 1 files changed

// File: rtl/ping_pong_counter.sv
// Bounded up/down counter that reverses at max/min, with a sticky one-shot flip request.
// Optional macro PPC_TICK_EDGE_EN: step on tick rising edges instead of while tick is high.
module ping_pong_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic             flip,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] min,
  output logic             direction,
  output logic [WIDTH-1:0] out,
  output logic             step
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_dir;
  logic             r_step;
  logic             r_flip_pending;
  logic             w_stb;
  logic             w_bounds_ok;
  logic             w_in_range;
  logic             w_step_ev;
  logic             w_ed;

`ifdef PPC_TICK_EDGE_EN
  logic r_tick_q;

  always_ff @(posedge clk) begin
    if (rst) r_tick_q <= 1'b0;
    else     r_tick_q <= tick;
  end

  assign w_stb = tick & ~r_tick_q;
`else
  assign w_stb = tick;
`endif

  // Out-of-range counts and degenerate bounds freeze the counter rather than wrap.
  assign w_bounds_ok = (max > min);
  assign w_in_range  = (r_out >= min) && (r_out <= max);
  assign w_step_ev   = w_stb & enable & w_bounds_ok & w_in_range;
  assign w_ed        = r_dir ^ (r_flip_pending | (flip & enable));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out          <= min;
      r_dir          <= 1'b1;
      r_step         <= 1'b0;
      r_flip_pending <= 1'b0;
    end else begin
      r_step <= w_step_ev;
      if (w_step_ev) begin
        r_flip_pending <= 1'b0;
        if (w_ed) begin
          if (r_out < max) begin
            r_out <= r_out + ONE;
            r_dir <= 1'b1;
          end else begin
            r_out <= max - ONE;
            r_dir <= 1'b0;
          end
        end else begin
          if (r_out > min) begin
            r_out <= r_out - ONE;
            r_dir <= 1'b0;
          end else begin
            r_out <= min + ONE;
            r_dir <= 1'b1;
          end
        end
      end else if (flip & enable) begin
        // Set-only: further requests before the step cannot cancel the reversal.
        r_flip_pending <= 1'b1;
      end
    end
  end

  assign out       = r_out;
  assign direction = r_dir;
  assign step      = r_step;

endmodule
